spi_master_gen: RTL

//  Parametrised SPI master on the 4-bit-address register bus: DATA_W-bit full-duplex frames,

---
 rtl/spi_master_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// spi_master_gen: register-mapped SPI master with DATA_W-bit full-duplex frames,
// programmable CPOL/CPHA, MSB/LSB-first ordering and NUM_CS active-low chip selects.
// Optional feature macro: SPI_IRQ_EN adds the registered o_irq output and the CTRL[7] IRQEN bit.
module spi_master_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 10,
    parameter int NUM_CS  = 2
) (
    input  logic              i_ck,
    input  logic              i_rstn,
    input  logic [3:0]        i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sclk,
    output logic [NUM_CS-1:0] o_csn,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_busy
`ifdef SPI_IRQ_EN
   ,output logic              o_irq
`endif
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(2 * DATA_W + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state, state_nxt;
    logic              cpol, cpha, lsbf;
    logic [2:0]        cssel;
    logic              irqen;
    logic [DATA_W-1:0] txdata, rxdata, tx_sh, rx_sh;
    logic              done, sclk_q, mosi_q, miso_s1, miso_s2;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     half;
    logic              busy, idle_wr, start, tick;
    logic              lead_edge, trail_edge, drive_evt, sample_evt, frame_end;
    logic [7:0]        ctrl_rd;
    logic [DATA_W-1:0] rd_mux;

    assign busy       = (state != IDLE);
    assign idle_wr    = i_wr && !busy;
    assign start      = idle_wr && (i_address == 4'd0) && i_data[0];
    assign tick       = (cnt == CNT_LAST);
    // SCLK toggles at the end of each half-period; even halves end on a leading edge.
    assign lead_edge  = (state == XFER) && tick && !half[0];
    assign trail_edge = (state == XFER) && tick && half[0];
    assign drive_evt  = cpha ? lead_edge : trail_edge;
    assign sample_evt = cpha ? trail_edge : lead_edge;
    assign frame_end  = (state == TRAIL) && tick;

`ifdef SPI_IRQ_EN
    assign ctrl_rd = {irqen, cssel, lsbf, cpha, cpol, 1'b0};
`else
    assign irqen   = 1'b0;
    assign ctrl_rd = {1'b0, cssel, lsbf, cpha, cpol, 1'b0};
`endif

    // State register.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state: LEAD and TRAIL last one divider period, XFER 2*DATA_W of them.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = LEAD;
            LEAD:  if (tick) state_nxt = XFER;
            XFER:  if (tick && half == HALF_LAST) state_nxt = TRAIL;
            TRAIL: if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider and half-period counters.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt  <= '0;
            half <= '0;
        end else begin
            cnt <= (!busy || tick) ? '0 : cnt + CW'(1);
            if (state != XFER) half <= '0;
            else if (tick)     half <= half + HW'(1);
        end
    end

    // Control and TXDATA registers; writable only while idle.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            cpol   <= 1'b0;
            cpha   <= 1'b0;
            lsbf   <= 1'b0;
            cssel  <= '0;
            txdata <= '0;
        end else if (idle_wr) begin
            if (i_address == 4'd0) begin
                cpol  <= i_data[1];
                cpha  <= i_data[2];
                lsbf  <= i_data[3];
                cssel <= i_data[6:4];
            end
            if (i_address == 4'd1) txdata <= i_data;
        end
    end

`ifdef SPI_IRQ_EN
    // Interrupt enable bit and registered interrupt output.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            irqen <= 1'b0;
            o_irq <= 1'b0;
        end else begin
            if (idle_wr && i_address == 4'd0) irqen <= i_data[7];
            o_irq <= done & irqen;
        end
    end
`endif

    // SCLK, MOSI and shift registers; CPHA=0 puts the first bit out at frame start.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            rxdata <= '0;
        end else begin
            if (state == LEAD)             sclk_q <= cpol;
            else if (state == XFER && tick) sclk_q <= ~sclk_q;
            if (start) begin
                if (i_data[2]) begin
                    mosi_q <= 1'b0;
                    tx_sh  <= txdata;
                end else if (i_data[3]) begin
                    mosi_q <= txdata[0];
                    tx_sh  <= {1'b0, txdata[DATA_W-1:1]};
                end else begin
                    mosi_q <= txdata[DATA_W-1];
                    tx_sh  <= {txdata[DATA_W-2:0], 1'b0};
                end
            end else if (drive_evt) begin
                mosi_q <= lsbf ? tx_sh[0] : tx_sh[DATA_W-1];
                tx_sh  <= lsbf ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
            end else if (frame_end) begin
                mosi_q <= 1'b0;
            end
            if (sample_evt)
                rx_sh <= lsbf ? {miso_s2, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso_s2};
            if (frame_end) rxdata <= rx_sh;
        end
    end

    // MISO two-flop synchroniser.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= i_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Sticky DONE: START clears first, frame end sets, RXDATA read clears.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn)                               done <= 1'b0;
        else if (start)                            done <= 1'b0;
        else if (frame_end)                        done <= 1'b1;
        else if (i_rd && i_address == 4'd2)        done <= 1'b0;
    end

    // Read mux over pre-write register values.
    always_comb begin
        rd_mux = '0;
        case (i_address)
            4'd0:    rd_mux = DATA_W'(ctrl_rd);
            4'd1:    rd_mux = txdata;
            4'd2:    rd_mux = rxdata;
            4'd3:    rd_mux = DATA_W'({done, busy});
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, zero when no read is in progress.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn)   o_data <= '0;
        else if (i_rd) o_data <= rd_mux;
        else           o_data <= '0;
    end

    // Pin outputs: selected chip select low while busy, SCLK parked at CPOL outside XFER.
    always_comb begin
        o_csn = '1;
        for (int unsigned i = 0; i < NUM_CS; i++)
            if (busy && cssel == 3'(i)) o_csn[i] = 1'b0;
        o_sclk = (state == XFER) ? sclk_q : cpol;
        o_mosi = mosi_q;
        o_busy = busy;
    end

endmodule
